// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// The only register with a dedicated write port is the stack pointer.
package rf_wb_arbiter_pkg;

  localparam int SP_IDX = 4;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_ALU  = 2'b01;
  localparam logic [1:0] GNT_MEM  = 2'b10;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (bit 0 = ALU, bit 1 = MEM).
// Combinational grant; the last-grant pointer updates only on advance.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic lg;

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_ALU;
      2'b10:   gnt = GNT_MEM;
      2'b11:   gnt = lg ? GNT_ALU : GNT_MEM;
      default: gnt = GNT_NONE;
    endcase
  end

  // Reset to MEM so the first contested grant goes to the ALU.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lg <= 1'b1;
    end else if (advance) begin
      lg <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter plus busy scoreboard in front of the register file.
// Writes are registered (one cycle); ALU/MEM never stall except on arbitration, ESP yields to a general SP write.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_wa,
  output logic              iss_ready,
  output logic [(1<<AW)-1:0] busy,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_wa,
  input  logic [DW-1:0]     alu_wd,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [AW-1:0]     mem_wa,
  input  logic [DW-1:0]     mem_wd,
  output logic              mem_ready,
  input  logic              sp_valid,
  input  logic [DW-1:0]     sp_wd,
  output logic              sp_ready,
  output logic              we,
  output logic [AW-1:0]     wa,
  output logic [DW-1:0]     wd,
  output logic              wesp,
  output logic [DW-1:0]     wdsp
);

  localparam logic [AW-1:0] SP_WA = SP_IDX[AW-1:0];

  logic [1:0]          gnt;
  logic                gen_fire;
  logic [AW-1:0]       gen_wa;
  logic [DW-1:0]       gen_wd;
  logic                sp_hit;
  logic                sp_fire;
  logic                iss_fire;
  logic [(1<<AW)-1:0]  busy_nxt;

  rr_arb2 u_arb (
    .clk     (clk),
    .n_rst   (n_rst),
    .req     ({mem_valid, alu_valid}),
    .advance (gen_fire),
    .gnt     (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];
  assign gen_fire  = gnt[0] | gnt[1];
  assign gen_wa    = gnt[1] ? mem_wa : alu_wa;
  assign gen_wd    = gnt[1] ? mem_wd : alu_wd;

  // A general write to SP in the same cycle wins; the ESP update retries next cycle.
  assign sp_hit   = gen_fire && (gen_wa == SP_WA) && sp_valid;
  assign sp_ready = ~sp_hit;
  assign sp_fire  = sp_valid & sp_ready;

  // Sampling the pre-clear flag refuses a same-cycle re-issue of a retiring register.
  assign iss_ready = ~busy[iss_wa];
  assign iss_fire  = iss_valid & iss_ready;

  always_comb begin
    busy_nxt = busy;
    if (gen_fire) begin
      busy_nxt[gen_wa] = 1'b0;
    end
    if (iss_fire) begin
      busy_nxt[iss_wa] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy <= '0;
      we   <= 1'b0;
      wa   <= '0;
      wd   <= '0;
      wesp <= 1'b0;
      wdsp <= '0;
    end else begin
      busy <= busy_nxt;
      we   <= gen_fire;
      wesp <= sp_fire;
      if (gen_fire) begin
        wa <= gen_wa;
        wd <= gen_wd;
      end
      if (sp_fire) begin
        wdsp <= sp_wd;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; register-file writes are checked against a scoreboard queue.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        iss_valid;
  logic [2:0]  iss_wa;
  logic        iss_ready;
  logic [7:0]  busy;
  logic        alu_valid;
  logic [2:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        mem_ready;
  logic        sp_valid;
  logic [31:0] sp_wd;
  logic        sp_ready;
  logic        we;
  logic [2:0]  wa;
  logic [31:0] wd;
  logic        wesp;
  logic [31:0] wdsp;

  int vectors = 0;
  int miscompares = 0;

  logic [34:0] gq[$];
  logic [31:0] sq[$];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(32), .AW(3)) dut (
    .clk(clk), .n_rst(n_rst),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_ready(iss_ready), .busy(busy),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .sp_valid(sp_valid), .sp_wd(sp_wd), .sp_ready(sp_ready),
    .we(we), .wa(wa), .wd(wd), .wesp(wesp), .wdsp(wdsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [34:0] ge;
    logic [31:0] se;
    if (n_rst === 1'b1) begin
      if (we) begin
        if (gq.size() == 0) chk("we_spurious", {63'b0, we}, 64'd0);
        else begin
          ge = gq.pop_front();
          chk("wa", {61'b0, wa}, {61'b0, ge[34:32]});
          chk("wd", {32'b0, wd}, {32'b0, ge[31:0]});
        end
      end
      if (wesp) begin
        if (sq.size() == 0) chk("wesp_spurious", {63'b0, wesp}, 64'd0);
        else begin
          se = sq.pop_front();
          chk("wdsp", {32'b0, wdsp}, {32'b0, se});
        end
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    iss_valid = 1'b1; iss_wa = 3'd0;
    alu_valid = 1'b1; alu_wa = 3'd1; alu_wd = 32'h11;
    mem_valid = 1'b1; mem_wa = 3'd2; mem_wd = 32'h22;
    sp_valid = 1'b1;  sp_wd = 32'h0;

    // Reset held with every source valid.
    cyc(); cyc();
    chk("rst_we", {63'b0, we}, 64'd0);
    chk("rst_wesp", {63'b0, wesp}, 64'd0);
    chk("rst_busy", {56'b0, busy}, 64'd0);
    iss_valid = 1'b0; sp_valid = 1'b0;
    n_rst = 1'b1;

    // Both sources valid: ALU first, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_alu_ready", {63'b0, alu_ready}, {63'b0, (i % 2 == 0)});
      chk("rr_mem_ready", {63'b0, mem_ready}, {63'b0, (i % 2 == 1)});
      if (i % 2 == 0) gq.push_back({3'd1, 32'h11});
      else            gq.push_back({3'd2, 32'h22});
      cyc();
      if (i > 0) chk("rr_we_back_to_back", {63'b0, we}, 64'd1);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Reserve r3, refuse a second reservation, retire with a load.
    iss_valid = 1'b1; iss_wa = 3'd3;
    @(negedge clk);
    chk("iss_r3_ready", {63'b0, iss_ready}, 64'd1);
    cyc();
    chk("busy_r3_set", {56'b0, busy}, 64'h08);
    @(negedge clk);
    chk("iss_r3_refused", {63'b0, iss_ready}, 64'd0);
    cyc();
    chk("busy_r3_hold", {56'b0, busy}, 64'h08);
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_wa = 3'd3; mem_wd = 32'hDEADBEEF;
    gq.push_back({3'd3, 32'hDEADBEEF});
    @(negedge clk);
    chk("mem_r3_ready", {63'b0, mem_ready}, 64'd1);
    cyc();
    chk("busy_r3_clear", {56'b0, busy}, 64'h00);
    mem_valid = 1'b0;

    // General write to SP collides with an ESP update; ESP goes a cycle later.
    alu_valid = 1'b1; alu_wa = 3'd4; alu_wd = 32'h100;
    sp_valid = 1'b1; sp_wd = 32'h200;
    gq.push_back({3'd4, 32'h100});
    @(negedge clk);
    chk("sp_alu_ready", {63'b0, alu_ready}, 64'd1);
    chk("sp_blocked", {63'b0, sp_ready}, 64'd0);
    cyc();
    alu_valid = 1'b0;
    sq.push_back(32'h200);
    @(negedge clk);
    chk("sp_ready_retry", {63'b0, sp_ready}, 64'd1);
    chk("wesp_low_on_collision", {63'b0, wesp}, 64'd0);
    cyc();
    sp_valid = 1'b0;

    // Same-cycle retire and re-issue of r5.
    iss_valid = 1'b1; iss_wa = 3'd5;
    cyc();
    chk("busy_r5_set", {56'b0, busy}, 64'h20);
    alu_valid = 1'b1; alu_wa = 3'd5; alu_wd = 32'h55;
    gq.push_back({3'd5, 32'h55});
    @(negedge clk);
    chk("race_iss_refused", {63'b0, iss_ready}, 64'd0);
    chk("race_alu_ready", {63'b0, alu_ready}, 64'd1);
    cyc();
    alu_valid = 1'b0;
    chk("race_busy_clear", {56'b0, busy}, 64'h00);
    @(negedge clk);
    chk("race_iss_retry", {63'b0, iss_ready}, 64'd1);
    cyc();
    chk("race_busy_set", {56'b0, busy}, 64'h20);
    iss_valid = 1'b0;

    // Retire r5, fill busy to 0x0F, then reset with a write in flight.
    alu_valid = 1'b1; alu_wa = 3'd5; alu_wd = 32'h5A;
    gq.push_back({3'd5, 32'h5A});
    cyc();
    alu_valid = 1'b0;
    iss_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      iss_wa = 3'(r);
      cyc();
    end
    iss_wa = 3'd3;
    alu_valid = 1'b1; alu_wa = 3'd7; alu_wd = 32'h77;
    cyc();
    chk("pre_rst_busy", {56'b0, busy}, 64'h0F);
    chk("pre_rst_we", {63'b0, we}, 64'd1);
    iss_valid = 1'b0;
    alu_wa = 3'd6; alu_wd = 32'h66;
    #1 n_rst = 1'b0;
    #1;
    chk("async_rst_busy", {56'b0, busy}, 64'h00);
    chk("async_rst_we", {63'b0, we}, 64'd0);
    @(negedge clk);
    alu_valid = 1'b0;
    cyc();
    n_rst = 1'b1;
    cyc();
    chk("post_rst_we", {63'b0, we}, 64'd0);
    chk("post_rst_busy", {56'b0, busy}, 64'h00);

    // Pointer is back to its reset value: contested grant goes to the ALU.
    alu_valid = 1'b1; alu_wa = 3'd1; alu_wd = 32'hA1;
    mem_valid = 1'b1; mem_wa = 3'd2; mem_wd = 32'hB2;
    gq.push_back({3'd1, 32'hA1});
    @(negedge clk);
    chk("post_rst_alu_first", {63'b0, alu_ready}, 64'd1);
    cyc();
    alu_valid = 1'b0; mem_valid = 1'b0;
    cyc(); cyc();

    chk("gen_queue_drained", 64'(gq.size()), 64'd0);
    chk("sp_queue_drained", 64'(sq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and register scoreboard in front of the 8-entry register file. It shares the single general write port between the ALU and memory-load result sources using round-robin arbitration. It serializes general writes to the stack pointer against the dedicated ESP write port, and it tracks which registers have an outstanding result so the issue stage can stall on hazards.

## Interface
Parameters:
- DW, default 32: data width.
- AW, default 3: register address width (2^AW registers).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- iss_valid  in  1  issue stage requests to reserve a destination.
- iss_wa  in  AW  destination register to reserve.
- iss_ready  out  1  reservation accepted this cycle.
- busy  out  2^AW  per-register pending-result flags.
- alu_valid  in  1  ALU result available.
- alu_wa  in  AW  ALU result destination.
- alu_wd  in  DW  ALU result data.
- alu_ready  out  1  ALU result accepted.
- mem_valid  in  1  load result available.
- mem_wa  in  AW  load result destination.
- mem_wd  in  DW  load result data.
- mem_ready  out  1  load result accepted.
- sp_valid  in  1  ESP update available (push/pop).
- sp_wd  in  DW  new ESP value.
- sp_ready  out  1  ESP update accepted.
- we, wa, wd  out  1/AW/DW  register-file general write port (registered).
- wesp, wdsp  out  1/DW  register-file ESP write port (registered).

## Operation
- Handshake: a transfer occurs on any rising edge where valid and ready are both high.
  - Ready signals are combinational from the valid inputs and internal state.
  - Ready never depends on the same source's data.
- General-port arbitration:
  - One-bit last-grant pointer `lg` (0 = ALU, 1 = MEM).
  - If only one of alu_valid or mem_valid is high, that source is granted.
  - If both are high, the source not equal to `lg` is granted.
  - `lg` updates only on a grant.
- SP collision: if the granted general write has wa == `SP and sp_valid is high, then sp_ready = 0 that cycle. The general write wins.
  - Otherwise sp_ready = sp_valid's acceptance (always ready).
- Scoreboard:
  - iss_ready = ~busy[iss_wa].
  - An accepted issue sets busy[iss_wa].
  - An accepted ALU/MEM transfer clears busy of its wa.
  - ESP-port writes never touch busy.
- Same cycle, same register, clear + issue: iss_ready still sees busy = 1, so the issue is refused. There is no set/clear race.
- A write to a register that is not busy is accepted and performed normally; busy stays 0.

## Timing
- Reset (n_rst = 0, asynchronous):
  - we = 0, wa = 0, wd = 0, wesp = 0, wdsp = 0.
  - busy = 0.
  - lg = 1 (ALU favoured first).
- Reset mid-operation discards any accepted-but-not-driven write.
- Latency: a transfer accepted at edge N drives we/wa/wd (or wesp/wdsp) during cycle N+1. The register file captures it at edge N+1.
- At most one general write and one ESP write per cycle.
- we and wesp are each high for exactly one cycle per accepted transfer and low otherwise.
- busy updates at the acceptance edge, one cycle before the register file holds the data. Issue logic reading the register file must wait one extra cycle after busy falls (documented bypass-free behaviour).
- Throughput: one general write per cycle sustained. With both sources continuously valid, grants alternate ALU, MEM, ALU, ...

## Structure
- Shared header: `SP (register index 4). Header constants only; no new typedefs.
- Sub-module rr_arb2: 2-requester round-robin arbiter holding the `lg` flop.
  - Inputs: req[1:0], advance.
  - Output: one-hot gnt[1:0].
- The top level holds the scoreboard vector, the collision logic and the output registers.

## Test plan
- Reset with all valid inputs high, then release -> we = wesp = 0 and busy = 0 during reset. First edge after release grants the ALU.
- alu_valid and mem_valid held high for 4 cycles (wa 1 and 2, wd 0x11/0x22) -> writes to r1, r2, r1, r2 on consecutive cycles; alu_ready/mem_ready alternate.
- iss_valid with iss_wa = 3 -> busy[3] = 1. A second issue of r3 is refused. mem write to r3 of 0xDEADBEEF -> busy[3] clears on the acceptance edge; we/wa = 3 the next cycle.
- alu_valid wa = 4, wd = 0x100 with sp_valid, sp_wd = 0x200 -> cycle 1: general write of 0x100 with sp_ready = 0. Cycle 2: wesp with 0x200, so the final ESP value is 0x200.
- alu write to r5 plus iss_wa = 5 in the same cycle while busy[5] = 1 -> busy[5] = 0 after the edge and iss_ready = 0. The issue is accepted the next cycle and busy[5] = 1.
- n_rst pulsed low mid-stream with busy = 0x0F -> busy = 0 and we = 0 immediately (asynchronous). No pending write appears after release.
